// File: rtl/dram_port_arbiter.sv
// dram_port_arbiter: shares the one-port data RAM between CPU and host.
// Define DRAM_ARB_HOST_WPROT_EN to reject host writes at/above HOST_WPROT_BASE.
module dram_port_arbiter #(
  parameter int ADDR_W          = 8,
  parameter int DATA_W          = 16,
  parameter int STARVE_LIMIT    = 4,
  parameter int HOST_WPROT_BASE = 'hF0
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              CPU_REQ,
  input  logic              CPU_WEN,
  input  logic [ADDR_W-1:0] CPU_ADDR,
  input  logic [DATA_W-1:0] CPU_WDATA,
  output logic              CPU_GNT,
  output logic              CPU_RVALID,
  output logic [DATA_W-1:0] CPU_RDATA,
  output logic              CPU_STALL,
  input  logic              HOST_REQ,
  input  logic              HOST_WEN,
  input  logic [ADDR_W-1:0] HOST_ADDR,
  input  logic [DATA_W-1:0] HOST_WDATA,
  output logic              HOST_GNT,
  output logic              HOST_RVALID,
  output logic [DATA_W-1:0] HOST_RDATA,
  output logic              HOST_ERR,
  output logic [ADDR_W-1:0] RAM_ADDR,
  output logic [DATA_W-1:0] RAM_IN,
  output logic              RAM_WEN,
  input  logic [DATA_W-1:0] RAM_OUT
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CPU_ACC  = 2'd1,
    HOST_ACC = 2'd2
  } state_t;

  localparam logic [3:0] LIM =
    4'(STARVE_LIMIT);
  localparam logic [ADDR_W-1:0] WP_BASE =
    ADDR_W'(HOST_WPROT_BASE);

`ifdef DRAM_ARB_HOST_WPROT_EN
  localparam logic WP_EN = 1'b1;
`else
  localparam logic WP_EN = 1'b0;
`endif

  state_t              state_q, state_d;
  logic [3:0]          starve_q, starve_d;
  logic                host_win, cpu_win;
  logic                host_wp;
  logic [ADDR_W-1:0]   ram_addr_q, addr_d;
  logic [DATA_W-1:0]   ram_in_q, wdata_d;
  logic                ram_wen_q, wen_d;
  logic                cpu_gnt_q, host_gnt_q;
  logic                host_err_q;
  logic                cpu_rd_q, host_rd_q;
  logic                cpu_rv_q, host_rv_q;
  logic [DATA_W-1:0]   cpu_rdata_q;
  logic [DATA_W-1:0]   host_rdata_q;

  // Winner selection: host only preempts an
  // idle CPU or one that has starved it.
  always_comb begin
    host_win = HOST_REQ &
      (~CPU_REQ | (starve_q == LIM));
    cpu_win  = CPU_REQ & ~host_win;
    host_wp  = WP_EN & HOST_WEN &
      (HOST_ADDR >= WP_BASE);
  end

  // Next RAM command and FSM state from
  // the winner; idle keeps addr/data.
  always_comb begin
    state_d = IDLE;
    addr_d  = ram_addr_q;
    wdata_d = ram_in_q;
    wen_d   = 1'b0;
    unique case (1'b1)
      host_win: begin
        state_d = HOST_ACC;
        addr_d  = HOST_ADDR;
        wdata_d = HOST_WDATA;
        wen_d   = HOST_WEN & ~host_wp;
      end
      cpu_win: begin
        state_d = CPU_ACC;
        addr_d  = CPU_ADDR;
        wdata_d = CPU_WDATA;
        wen_d   = CPU_WEN;
      end
      default: ;
    endcase
  end

  // Count CPU wins while the host waits,
  // saturating at the starvation limit.
  always_comb begin
    starve_d = starve_q;
    if (host_win || !HOST_REQ)
      starve_d = 4'd0;
    else if (cpu_win && starve_q != LIM)
      starve_d = starve_q + 4'd1;
  end

  // Registered FSM, RAM command, grants and
  // the two-stage read-owner pipeline.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= IDLE;
      starve_q     <= 4'd0;
      ram_addr_q   <= '0;
      ram_in_q     <= '0;
      ram_wen_q    <= 1'b0;
      cpu_gnt_q    <= 1'b0;
      host_gnt_q   <= 1'b0;
      host_err_q   <= 1'b0;
      cpu_rd_q     <= 1'b0;
      host_rd_q    <= 1'b0;
      cpu_rv_q     <= 1'b0;
      host_rv_q    <= 1'b0;
      cpu_rdata_q  <= '0;
      host_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      ram_addr_q <= addr_d;
      ram_in_q   <= wdata_d;
      ram_wen_q  <= wen_d;
      cpu_gnt_q  <= cpu_win;
      host_gnt_q <= host_win;
      host_err_q <= host_win & host_wp;
      cpu_rd_q   <= cpu_win & ~CPU_WEN;
      host_rd_q  <= host_win & ~HOST_WEN;
      cpu_rv_q   <= cpu_rd_q;
      host_rv_q  <= host_rd_q;
      if (cpu_rv_q)
        cpu_rdata_q <= RAM_OUT;
      if (host_rv_q)
        host_rdata_q <= RAM_OUT;
    end
  end

  assign CPU_GNT     = cpu_gnt_q;
  assign HOST_GNT    = host_gnt_q;
  assign HOST_ERR    = host_err_q;
  assign RAM_ADDR    = ram_addr_q;
  assign RAM_IN      = ram_in_q;
  assign RAM_WEN     = ram_wen_q;
  assign CPU_RVALID  = cpu_rv_q;
  assign HOST_RVALID = host_rv_q;
  assign CPU_RDATA   =
    cpu_rv_q ? RAM_OUT : cpu_rdata_q;
  assign HOST_RDATA  =
    host_rv_q ? RAM_OUT : host_rdata_q;
  assign CPU_STALL   = RESET_N & CPU_REQ &
    (~cpu_win | (state_q == HOST_ACC));

endmodule
